// File: rtl/cmp_result_monitor.sv
// rtl/cmp_result_monitor.sv - outcome counters, equal-run FSM and error flag for comparator results
module cmp_result_monitor #(
    parameter int CNT_W   = 8,
    parameter int RUN_THR = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    input  logic             in_lt,
    input  logic             in_gt,
    input  logic             in_eq,
    output logic             out_valid,
    output logic [1:0]       last_result,
    output logic [CNT_W-1:0] lt_cnt,
    output logic [CNT_W-1:0] gt_cnt,
    output logic [CNT_W-1:0] eq_cnt,
    output logic [CNT_W-1:0] eq_run,
    output logic             run_alarm,
    output logic             err_flag
);

    typedef enum logic [1:0] {
        S_NEUTRAL = 2'd0,
        S_EQ_RUN  = 2'd1,
        S_ALARM   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] THR     = CNT_W'(RUN_THR);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_eq_run;
    logic [CNT_W-1:0] w_run_nxt;
    logic [CNT_W-1:0] w_run_inc;
    logic [CNT_W-1:0] r_lt_cnt;
    logic [CNT_W-1:0] r_gt_cnt;
    logic [CNT_W-1:0] r_eq_cnt;
    logic [1:0]       r_last;
    logic             r_out_valid;
    logic             r_err;
    logic [2:0]       w_flags;
    logic             w_legal;
    logic             w_sample;

    assign w_flags   = {in_lt, in_gt, in_eq};
    assign w_legal   = (w_flags == 3'b100) || (w_flags == 3'b010) || (w_flags == 3'b001);
    // clr wins over a sample presented in the same cycle
    assign w_sample  = in_valid && !clr;
    assign w_run_inc = (r_eq_run == CNT_MAX) ? CNT_MAX : r_eq_run + 1'b1;

    // State register and the equal-run length that travels with it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_NEUTRAL;
            r_eq_run <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_eq_run <= w_run_nxt;
        end
    end

    // Next state: only eq extends a run; anything else valid drops back to NEUTRAL
    always_comb begin
        w_state_nxt = r_state;
        w_run_nxt   = r_eq_run;
        if (clr) begin
            w_state_nxt = S_NEUTRAL;
            w_run_nxt   = '0;
        end else if (in_valid) begin
            if (!w_legal || !in_eq) begin
                w_state_nxt = S_NEUTRAL;
                w_run_nxt   = '0;
            end else begin
                case (r_state)
                    S_NEUTRAL: begin
                        w_run_nxt   = {{(CNT_W-1){1'b0}}, 1'b1};
                        w_state_nxt = (RUN_THR == 1) ? S_ALARM : S_EQ_RUN;
                    end
                    S_EQ_RUN: begin
                        w_run_nxt   = w_run_inc;
                        w_state_nxt = (w_run_inc == THR) ? S_ALARM : S_EQ_RUN;
                    end
                    S_ALARM: begin
                        w_run_nxt   = w_run_inc;
                        w_state_nxt = S_ALARM;
                    end
                    default: begin
                        w_run_nxt   = '0;
                        w_state_nxt = S_NEUTRAL;
                    end
                endcase
            end
        end
    end

    // Saturating per-outcome counters, last result code and sticky error flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lt_cnt    <= '0;
            r_gt_cnt    <= '0;
            r_eq_cnt    <= '0;
            r_last      <= 2'b00;
            r_out_valid <= 1'b0;
            r_err       <= 1'b0;
        end else if (clr) begin
            r_lt_cnt    <= '0;
            r_gt_cnt    <= '0;
            r_eq_cnt    <= '0;
            r_last      <= 2'b00;
            r_out_valid <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_out_valid <= w_sample;
            if (w_sample) begin
                if (!w_legal) begin
                    r_err  <= 1'b1;
                    r_last <= 2'b00;
                end else if (in_lt) begin
                    r_last <= 2'b01;
                    if (r_lt_cnt != CNT_MAX) r_lt_cnt <= r_lt_cnt + 1'b1;
                end else if (in_gt) begin
                    r_last <= 2'b10;
                    if (r_gt_cnt != CNT_MAX) r_gt_cnt <= r_gt_cnt + 1'b1;
                end else begin
                    r_last <= 2'b11;
                    if (r_eq_cnt != CNT_MAX) r_eq_cnt <= r_eq_cnt + 1'b1;
                end
            end
        end
    end

    assign out_valid   = r_out_valid;
    assign last_result = r_last;
    assign lt_cnt      = r_lt_cnt;
    assign gt_cnt      = r_gt_cnt;
    assign eq_cnt      = r_eq_cnt;
    assign eq_run      = r_eq_run;
    assign run_alarm   = (r_state == S_ALARM);
    assign err_flag    = r_err;

endmodule
